// File: rtl/phy_pkg.sv
// Shared PHY datapath definitions: symbol width, the K28.5 comma symbol
// and the serializer state encoding.
package phy_pkg;

   localparam int W = 10;

   // K28.5, running disparity negative
   localparam logic [W-1:0] K28_5 = 10'b0011111010;

   typedef enum logic [0:0] {
      DISABLED = 1'b0,
      SEND     = 1'b1
   } state_e;

endpackage

// File: rtl/ps_shift_reg.sv
// W-bit shift register with automatic parallel load at each symbol boundary.
// The MSB is the serial output; the bit counter marks the boundary.
module ps_shift_reg #(
   parameter int W = phy_pkg::W
) (
   input  logic         CLOCK,
   input  logic         RESET_L,
   input  logic [W-1:0] din,
   output logic         sout,
   output logic         boundary
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  shift;
   logic [CW-1:0] bitcnt;

   // Reset parks the counter on the last bit so the first edge after release is a boundary
   always_ff @(posedge CLOCK) begin
      if (!RESET_L) begin
         shift  <= '0;
         bitcnt <= CW'(W - 1);
      end else if (boundary) begin
         shift  <= din;
         bitcnt <= '0;
      end else begin
         shift  <= {shift[W-2:0], 1'b0};
         bitcnt <= bitcnt + CW'(1);
      end
   end

   assign boundary = (bitcnt == CW'(W - 1));
   assign sout     = shift[W-1];

endmodule

// File: rtl/paraleloserial_tx.sv
// Parallel-to-serial transmit stage: one-deep holding register, idle comma
// insertion on underrun, and sticky overrun on dropped loads.
module paraleloserial_tx #(
   parameter int           W        = phy_pkg::W,
   parameter logic [W-1:0] IDLE_SYM = W'(phy_pkg::K28_5)
) (
   input  logic         CLOCK,
   input  logic         RESET_L,
   input  logic         LOADS,
   input  logic         IS,
   input  logic [W-1:0] D,
   output logic         SOUT,
   output logic         FRAME,
   output logic         DATA_ACT,
   output logic         UNDERRUN,
   output logic         OVERRUN
);

   import phy_pkg::*;

   state_e       state;
   logic [W-1:0] hold;
   logic         hold_full;
   logic         boundary;
   logic [W-1:0] next_sym;
   logic         take_hold;
   logic         load_ok;
   logic         drop;

   // NOTE: every always_comb output gets a default/complete assignment so no latch is inferred.
   always_comb begin
      take_hold = boundary && (state == SEND) && IS && hold_full;
      next_sym  = take_hold ? hold : IDLE_SYM;
      load_ok   = (state == SEND) && LOADS && IS && (!hold_full || take_hold);
      drop      = (state == SEND) && LOADS && IS && hold_full && !take_hold;
   end

   ps_shift_reg #(.W(W)) u_shift (
      .CLOCK    (CLOCK),
      .RESET_L  (RESET_L),
      .din      (next_sym),
      .sout     (SOUT),
      .boundary (boundary)
   );

   // NOTE: hold is pure data qualified by hold_full, so it is deliberately left out of reset.
   always_ff @(posedge CLOCK) begin
      if (load_ok)
         hold <= D;
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET_L) begin
         state     <= DISABLED;
         hold_full <= 1'b0;
         FRAME     <= 1'b0;
         DATA_ACT  <= 1'b0;
         UNDERRUN  <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         if (boundary) begin
            state    <= IS ? SEND : DISABLED;
            FRAME    <= 1'b1;
            DATA_ACT <= take_hold;
            UNDERRUN <= IS && !take_hold;
         end else begin
            FRAME    <= 1'b0;
            UNDERRUN <= 1'b0;
         end

         // A boundary that drops IS discards whatever is pending
         if ((state == DISABLED) || (boundary && !IS))
            hold_full <= 1'b0;
         else if (load_ok)
            hold_full <= 1'b1;
         else if (take_hold)
            hold_full <= 1'b0;

         if (drop)
            OVERRUN <= 1'b1;
      end
   end

endmodule

// File: tb/tb_paraleloserial_tx.sv
// Directed, table-driven bench for paraleloserial_tx with hand-computed
// per-cycle expectations {SOUT, FRAME, DATA_ACT, UNDERRUN, OVERRUN}.
module tb_paraleloserial_tx;

   localparam logic [9:0] IDLE = 10'b0011111010;

   logic       CLOCK = 1'b0;
   logic       RESET_L;
   logic       LOADS;
   logic       IS;
   logic [9:0] D;
   logic       SOUT, FRAME, DATA_ACT, UNDERRUN, OVERRUN;

   paraleloserial_tx dut (
      .CLOCK    (CLOCK),
      .RESET_L  (RESET_L),
      .LOADS    (LOADS),
      .IS       (IS),
      .D        (D),
      .SOUT     (SOUT),
      .FRAME    (FRAME),
      .DATA_ACT (DATA_ACT),
      .UNDERRUN (UNDERRUN),
      .OVERRUN  (OVERRUN)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic       rstn;
      logic       loads;
      logic       is;
      logic [9:0] d;
      logic [4:0] exp;  // {sout, frame, data_act, underrun, overrun}
   } vec_t;

   vec_t tbl [0:299];
   int   n = 0;
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      @(negedge CLOCK);
   endtask

   task automatic add_sym(input logic [9:0] sym, input logic act, input logic und,
                          input logic ovr, input logic is_v);
      for (int b = 0; b < 10; b++) begin
         tbl[n].rstn  = 1'b1;
         tbl[n].loads = 1'b0;
         tbl[n].is    = is_v;
         tbl[n].d     = '0;
         tbl[n].exp   = {sym[9-b], (b == 0), act, und && (b == 0), ovr};
         n++;
      end
   endtask

   task automatic set_load(input int idx, input logic [9:0] dv);
      tbl[idx].loads = 1'b1;
      tbl[idx].d     = dv;
   endtask

   initial begin
      int b;
      int cnt;
      logic [9:0] cap;

      // Phase A: idle comma stream with one underrun per symbol
      add_sym(IDLE, 0, 1, 0, 1);
      add_sym(IDLE, 0, 1, 0, 1);
      // Phase B: load on a boundary edge -> idle first, 2AA one symbol later
      b = n;
      add_sym(IDLE, 0, 1, 0, 1);
      set_load(b, 10'h2AA);
      add_sym(10'h2AA, 1, 0, 0, 1);
      add_sym(IDLE, 0, 1, 0, 1);
      // Phase C: counting symbols, loads phase-locked (boundary loads refill HOLD)
      b = n;
      add_sym(IDLE, 0, 1, 0, 1);
      for (int s = 0; s < 4; s++) add_sym(10'(s), 1, 0, 0, 1);
      add_sym(IDLE, 0, 1, 0, 1);
      set_load(b + 1, 10'h000);
      set_load(b + 10, 10'h001);
      set_load(b + 20, 10'h002);
      set_load(b + 30, 10'h003);
      // Phase D: two back-to-back loads mid-symbol -> second dropped, OVERRUN sticky
      b = n;
      add_sym(IDLE, 0, 1, 0, 1);
      set_load(b + 3, 10'h155);
      set_load(b + 4, 10'h3FF);
      for (int i = b + 4; i < b + 10; i++) tbl[i].exp[0] = 1'b1;
      add_sym(10'h155, 1, 0, 1, 1);
      add_sym(IDLE, 0, 1, 1, 1);
      // Phase E: IS dropped mid data symbol with HOLD full
      b = n;
      add_sym(IDLE, 0, 1, 1, 1);
      set_load(b + 1, 10'h0F0);
      add_sym(10'h0F0, 1, 0, 1, 1);
      set_load(b + 11, 10'h33C);
      for (int i = b + 14; i < b + 20; i++) tbl[i].is = 1'b0;
      add_sym(IDLE, 0, 0, 1, 0);
      for (int i = b + 21; i < b + 30; i++) tbl[i].is = 1'b1;
      add_sym(IDLE, 0, 1, 1, 1);
      add_sym(IDLE, 0, 1, 1, 1);
      // Phase F: reset asserted at bit 5 of a data symbol
      b = n;
      add_sym(IDLE, 0, 1, 1, 1);
      set_load(b + 1, 10'h3C3);
      add_sym(10'h3C3, 1, 0, 1, 1);
      n = b + 15;
      for (int r = 0; r < 2; r++) begin
         tbl[n].rstn  = 1'b0;
         tbl[n].loads = 1'b0;
         tbl[n].is    = 1'b1;
         tbl[n].d     = '0;
         tbl[n].exp   = 5'b00000;
         n++;
      end
      add_sym(IDLE, 0, 1, 0, 1);
      add_sym(IDLE, 0, 1, 0, 1);

      // Power-on reset
      RESET_L = 1'b0;
      LOADS   = 1'b0;
      IS      = 1'b1;
      D       = '0;
      tick();
      tick();
      check("rst_sout",     {9'd0, SOUT},     10'd0);
      check("rst_frame",    {9'd0, FRAME},    10'd0);
      check("rst_data_act", {9'd0, DATA_ACT}, 10'd0);
      check("rst_underrun", {9'd0, UNDERRUN}, 10'd0);
      check("rst_overrun",  {9'd0, OVERRUN},  10'd0);

      for (int i = 0; i < n; i++) begin
         RESET_L = tbl[i].rstn;
         LOADS   = tbl[i].loads;
         IS      = tbl[i].is;
         D       = tbl[i].d;
         tick();
         check($sformatf("vec%0d", i),
               {5'd0, SOUT, FRAME, DATA_ACT, UNDERRUN, OVERRUN},
               {5'd0, tbl[i].exp});
      end

      // Hand sequence: load on a boundary, measure latency, reassemble the symbol
      RESET_L = 1'b1;
      IS      = 1'b1;
      LOADS   = 1'b1;
      D       = 10'h2D4;
      tick();
      LOADS = 1'b0;
      D     = '0;
      cnt   = 0;
      while (!(FRAME && DATA_ACT) && cnt < 25) begin
         tick();
         cnt++;
      end
      check("latency", 10'(cnt), 10'd10);
      cap = '0;
      for (int k = 0; k < 10; k++) begin
         cap = {cap[8:0], SOUT};
         if (k < 9) tick();
      end
      check("serial_2d4", cap, 10'h2D4);
      tick();
      check("after_2d4_underrun", {8'd0, UNDERRUN, DATA_ACT}, 10'b10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
